// File: rtl/oldland_dmem_access.sv
// -----------------------------------------------------------------------------
// oldland_dmem_access
//   Data-memory access stage. Accepts a single load or store from the
//   execute stage, checks alignment, drives one bus transaction and either
//   writes the loaded value back to the register file or raises a data abort.
//   Non-memory results are passed straight through to writeback with one
//   cycle of latency.
//
// Handshake: a request (mem_load/mem_store/wr_result) is a one-cycle strobe
//   sampled only while idle. d_access is asserted and held, with the address,
//   lane enables and write data frozen, until the bus answers with d_ack or
//   d_error (d_error wins if both are high) or the timeout expires. busy is
//   high exactly while d_access is held; upstream must not issue requests
//   while busy is high.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   mem_load, mem_store       one-cycle load/store strobes (both = store)
//   mem_width                 00 byte, 01 half, 10 word, 11 reserved
//   mar, mdr                  byte address, right-justified store data
//   rd_sel                    destination register for loads / wr_result
//   wr_result, wr_val         non-memory writeback request and value
//   d_addr .. d_access        bus request side (registered)
//   d_ack, d_error, d_data    bus response side
//   busy                      transaction outstanding
//   wb_en, wb_sel, wb_val     register writeback strobe and payload
//   data_abort, abort_addr    one-cycle abort pulse and faulting address
// -----------------------------------------------------------------------------
module oldland_dmem_access #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_load,
   input  logic        mem_store,
   input  logic [1:0]  mem_width,
   input  logic [31:0] mar,
   input  logic [31:0] mdr,
   input  logic [3:0]  rd_sel,
   input  logic        wr_result,
   input  logic [31:0] wr_val,
   output logic [29:0] d_addr,
   output logic [3:0]  d_bytesel,
   output logic        d_wr_en,
   output logic [31:0] d_wr_val,
   output logic        d_access,
   input  logic        d_ack,
   input  logic        d_error,
   input  logic [31:0] d_data,
   output logic        busy,
   output logic        wb_en,
   output logic [3:0]  wb_sel,
   output logic [31:0] wb_val,
   output logic        data_abort,
   output logic [31:0] abort_addr
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // The counter stops at TMO_LAST, so it never wraps.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;

   logic [29:0] d_addr_q, d_addr_d;
   logic [3:0]  d_bytesel_q, d_bytesel_d;
   logic        d_wr_en_q, d_wr_en_d;
   logic [31:0] d_wr_val_q, d_wr_val_d;
   logic        d_access_q, d_access_d;
   logic        busy_q, busy_d;
   logic        wb_en_q, wb_en_d;
   logic [3:0]  wb_sel_q, wb_sel_d;
   logic [31:0] wb_val_q, wb_val_d;
   logic        data_abort_q, data_abort_d;
   logic [31:0] abort_addr_q, abort_addr_d;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;

   // Transaction context kept for the load-data lane select.
   logic [1:0]  width_q, width_d;
   logic [1:0]  lo_q, lo_d;
   logic        is_load_q, is_load_d;
   logic [3:0]  rd_sel_q, rd_sel_d;

   logic        req;
   logic        legal;
   logic [3:0]  bytesel_calc;
   logic [31:0] wr_val_calc;
   logic [31:0] load_val;

   assign req = mem_load | mem_store;

   // Request decode: alignment check, lane enables and replicated store data.
   always_comb begin
      legal        = 1'b1;
      bytesel_calc = 4'b0000;
      wr_val_calc  = mdr;
      case (mem_width)
         2'b00: begin
            bytesel_calc = 4'b0001 << mar[1:0];
            wr_val_calc  = {4{mdr[7:0]}};
         end
         2'b01: begin
            legal        = ~mar[0];
            bytesel_calc = mar[1] ? 4'b1100 : 4'b0011;
            wr_val_calc  = {2{mdr[15:0]}};
         end
         2'b10: begin
            legal        = (mar[1:0] == 2'b00);
            bytesel_calc = 4'b1111;
            wr_val_calc  = mdr;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

   // Pick the addressed lane from the read data and zero-extend it.
   always_comb begin
      load_val = d_data;
      case (width_q)
         2'b00: begin
            case (lo_q)
               2'b00:   load_val = {24'd0, d_data[7:0]};
               2'b01:   load_val = {24'd0, d_data[15:8]};
               2'b10:   load_val = {24'd0, d_data[23:16]};
               default: load_val = {24'd0, d_data[31:24]};
            endcase
         end
         2'b01:   load_val = lo_q[1] ? {16'd0, d_data[31:16]} : {16'd0, d_data[15:0]};
         default: load_val = d_data;
      endcase
   end

   // Next-state and next-output logic. Everything holds by default except
   // the two pulse outputs, which default low.
   always_comb begin
      state_d      = state_q;
      d_addr_d     = d_addr_q;
      d_bytesel_d  = d_bytesel_q;
      d_wr_en_d    = d_wr_en_q;
      d_wr_val_d   = d_wr_val_q;
      d_access_d   = d_access_q;
      busy_d       = busy_q;
      wb_en_d      = 1'b0;
      wb_sel_d     = wb_sel_q;
      wb_val_d     = wb_val_q;
      data_abort_d = 1'b0;
      abort_addr_d = abort_addr_q;
      tmo_cnt_d    = tmo_cnt_q;
      width_d      = width_q;
      lo_d         = lo_q;
      is_load_d    = is_load_q;
      rd_sel_d     = rd_sel_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (legal) begin
                  state_d     = ACCESS;
                  d_addr_d    = mar[31:2];
                  d_bytesel_d = bytesel_calc;
                  d_wr_en_d   = mem_store;
                  d_wr_val_d  = wr_val_calc;
                  d_access_d  = 1'b1;
                  busy_d      = 1'b1;
                  tmo_cnt_d   = 8'd0;
                  width_d     = mem_width;
                  lo_d        = mar[1:0];
                  is_load_d   = ~mem_store;
                  rd_sel_d    = rd_sel;
               end else begin
                  data_abort_d = 1'b1;
                  abort_addr_d = mar;
               end
            end else if (wr_result) begin
               wb_en_d  = 1'b1;
               wb_sel_d = rd_sel;
               wb_val_d = wr_val;
            end
         end

         ACCESS: begin
            if (d_error || (!d_ack && tmo_cnt_q == TMO_LAST)) begin
               state_d      = IDLE;
               d_access_d   = 1'b0;
               d_wr_en_d    = 1'b0;
               busy_d       = 1'b0;
               data_abort_d = 1'b1;
               abort_addr_d = {d_addr_q, lo_q};
            end else if (d_ack) begin
               state_d    = IDLE;
               d_access_d = 1'b0;
               d_wr_en_d  = 1'b0;
               busy_d     = 1'b0;
               if (is_load_q) begin
                  wb_en_d  = 1'b1;
                  wb_sel_d = rd_sel_q;
                  wb_val_d = load_val;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         d_addr_q     <= 30'd0;
         d_bytesel_q  <= 4'd0;
         d_wr_en_q    <= 1'b0;
         d_wr_val_q   <= 32'd0;
         d_access_q   <= 1'b0;
         busy_q       <= 1'b0;
         wb_en_q      <= 1'b0;
         wb_sel_q     <= 4'd0;
         wb_val_q     <= 32'd0;
         data_abort_q <= 1'b0;
         abort_addr_q <= 32'd0;
         tmo_cnt_q    <= 8'd0;
         width_q      <= 2'd0;
         lo_q         <= 2'd0;
         is_load_q    <= 1'b0;
         rd_sel_q     <= 4'd0;
      end else begin
         state_q      <= state_d;
         d_addr_q     <= d_addr_d;
         d_bytesel_q  <= d_bytesel_d;
         d_wr_en_q    <= d_wr_en_d;
         d_wr_val_q   <= d_wr_val_d;
         d_access_q   <= d_access_d;
         busy_q       <= busy_d;
         wb_en_q      <= wb_en_d;
         wb_sel_q     <= wb_sel_d;
         wb_val_q     <= wb_val_d;
         data_abort_q <= data_abort_d;
         abort_addr_q <= abort_addr_d;
         tmo_cnt_q    <= tmo_cnt_d;
         width_q      <= width_d;
         lo_q         <= lo_d;
         is_load_q    <= is_load_d;
         rd_sel_q     <= rd_sel_d;
      end
   end

   assign d_addr     = d_addr_q;
   assign d_bytesel  = d_bytesel_q;
   assign d_wr_en    = d_wr_en_q;
   assign d_wr_val   = d_wr_val_q;
   assign d_access   = d_access_q;
   assign busy       = busy_q;
   assign wb_en      = wb_en_q;
   assign wb_sel     = wb_sel_q;
   assign wb_val     = wb_val_q;
   assign data_abort = data_abort_q;
   assign abort_addr = abort_addr_q;

endmodule

// File: doc/oldland_dmem_access.md
OLDLAND_DMEM_ACCESS -- requirements
Module: oldland_dmem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max cycles from d_access to d_ack/d_error before abort (legal 1..255).
REQ-002 SHALL have ports (clock and reset first):
 clk  input  1  sole clock, all state on rising edge
 rst  input  1  asynchronous, active-low reset
 mem_load  input  1  load request, valid for one cycle
 mem_store  input  1  store request, valid for one cycle
 mem_width  input  2  00 byte, 01 half, 10 word, 11 reserved
 mar  input  32  byte address
 mdr  input  32  store data, right-justified
 rd_sel  input  4  load destination register
 wr_result  input  1  non-memory writeback request
 wr_val  input  32  non-memory writeback value
 d_addr  output  30  word address, mar[31:2]
 d_bytesel  output  4  byte-lane enables
 d_wr_en  output  1  1 = write cycle
 d_wr_val  output  32  lane-replicated store data
 d_access  output  1  bus request, held until d_ack or d_error
 d_ack  input  1  bus completion
 d_error  input  1  bus error completion
 d_data  input  32  read data, valid with d_ack
 busy  output  1  transaction outstanding; upstream stalls
 wb_en  output  1  register writeback strobe
 wb_sel  output  4  writeback register
 wb_val  output  32  writeback value
 data_abort  output  1  one-cycle abort pulse
 abort_addr  output  32  faulting byte address

Function
REQ-003 SHALL implement states IDLE, ACCESS; request = (mem_load | mem_store) sampled in IDLE.
REQ-004 SHALL, in IDLE with request and legal alignment/width, latch address/width/data/rd_sel, assert d_access next cycle, enter ACCESS, raise busy the same next cycle.
REQ-005 SHALL treat as illegal: width 11; half with mar[0]=1; word with mar[1:0]!=00; illegal request SHALL issue no bus cycle, pulse data_abort next cycle with abort_addr=mar, stay IDLE, no writeback.
REQ-006 SHALL drive d_bytesel: byte -> 1<<mar[1:0]; half -> 0011 (mar[1]=0) or 1100; word -> 1111.
REQ-007 SHALL drive d_wr_val: byte -> mdr[7:0] replicated x4; half -> mdr[15:0] x2; word -> mdr.
REQ-008 SHALL hold d_addr, d_bytesel, d_wr_en, d_wr_val stable while d_access=1.
REQ-009 SHALL, in ACCESS on d_ack (d_error=0), drop d_access and busy next cycle and return to IDLE; load SHALL pulse wb_en with wb_sel=latched rd_sel, wb_val=selected lane zero-extended; store SHALL not write back.
REQ-010 SHALL, on d_error, or d_ack absent for TIMEOUT_CYCLES cycles after d_access rises, drop d_access, pulse data_abort, abort_addr=latched address, no writeback, return to IDLE.
REQ-011 SHALL give d_error priority over d_ack when both asserted.
REQ-012 SHALL clear the timeout counter on each entry to ACCESS; counter SHALL not wrap.
REQ-013 SHALL pass non-memory writeback with one-cycle latency: wr_result in IDLE with no request -> wb_en=1, wb_sel=rd_sel, wb_val=wr_val next cycle.
REQ-014 SHALL ignore mem_load, mem_store, wr_result while busy=1 (upstream guarantees none).
REQ-015 SHALL treat mem_load and mem_store both high as a store.
REQ-016 SHALL register all outputs; wb_en and data_abort never high in the same cycle.

Reset
REQ-017 SHALL, on rst low, immediately enter IDLE and clear d_access, d_wr_en, busy, wb_en, data_abort, timeout counter, d_bytesel, d_addr, d_wr_val, wb_sel, wb_val, abort_addr to 0.
REQ-018 SHALL, on reset mid-ACCESS, abandon the transaction with no writeback or abort; first request after rst rises SHALL be accepted normally.

Verification
REQ-019 Load byte mar=0x1003, width 00, rd_sel=5; d_data=0xAB000000 on d_ack -> d_bytesel=1000, wb_en, wb_sel=5, wb_val=0x000000AB.
REQ-020 Store half mar=0x2002, mdr=0x1234BEEF -> d_wr_en=1, d_bytesel=1100, d_wr_val=0xBEEFBEEF, no wb_en, busy drops cycle after d_ack.
REQ-021 Load word mar=0x3001 -> no d_access, data_abort pulse, abort_addr=0x3001.
REQ-022 Load word mar=0x4000, TIMEOUT_CYCLES=4, no d_ack -> d_access high exactly 4 cycles, then data_abort, abort_addr=0x4000.
REQ-023 d_ack and d_error together on store mar=0x5000 -> data_abort, no wb_en; rst low during ACCESS -> d_access, busy 0 immediately, no abort.
REQ-024 wr_result=1, rd_sel=3, wr_val=0xCAFEF00D in IDLE -> next cycle wb_en, wb_sel=3, wb_val=0xCAFEF00D, no bus cycle.
